// File: rtl/uart_rx_ctrl_pkg.sv
// Shared frame, state and result types for the UART receiver.
// The decode helper turns a captured 11-bit frame into data and error flags.
package pkg_uart;

  localparam int FW            = 11;
  localparam int BAUD_DIV_DFLT = 434;

  typedef logic [FW-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    CHECK
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_result_t;

  // Frame layout, LSB first: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic rx_result_t decode(frame_t f, logic odd);
    rx_result_t r;
    r.data = f[8:1];
    r.perr = (^f[9:1]) ^ odd;
    r.ferr = ~f[10];
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line input and received-byte outputs of the UART receiver.
// The master side drives the line; the slave side is the receiver.
interface uart_rx_ctrl_if;

  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    input  i_rx,
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

endinterface

// File: rtl/uart_rx_ctrl_sipo.sv
// 11-bit serial-in parallel-out register, shifting toward bit0 so the
// first bit received (start) ends up in bit0 after a full frame.
module sipo_dw_11
  import pkg_uart::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_ena,
  input  logic   i_val,
  output frame_t o_frame
);

  frame_t sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (i_ena) begin
      sr <= {i_val, sr[FW-1:1]};
    end
  end

  assign o_frame = sr;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizer, start-edge detect, mid-bit sampling FSM and
// registered byte/error outputs. 8 data bits, one parity bit, one stop bit.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a 1->0 edge on the synchronized line
//   START | counting to mid start bit; confirm low or drop as glitch
//   DATA  | sampling d0..d7, parity and stop once per bit period
//   CHECK | one cycle: publish byte, error flags and the valid pulse
module uart_rx_ctrl
  import pkg_uart::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DFLT,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);

  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_MAX = 4'(FW);
  localparam logic [3:0]  BIT_STP = 4'(FW - 1);

  logic        rx_m, rx_s, rx_q;
  state_t      state;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        sh_ena;
  frame_t      frame;
  rx_result_t  res;
  logic        frame_unused;

  logic [7:0]  data_q;
  logic        valid_q, perr_q, ferr_q, busy_q;

  // Reset to the idle level so release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= bus.i_rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  always_comb begin
    sh_ena = 1'b0;
    case (state)
      START:   sh_ena = (baud_cnt == HALF_M1) && !rx_s;
      DATA:    sh_ena = (baud_cnt == FULL_M1);
      default: sh_ena = 1'b0;
    endcase
  end

  sipo_dw_11 u_sipo (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (sh_ena),
    .i_val   (rx_s),
    .o_frame (frame)
  );

  assign res          = decode(frame, ODD_PARITY);
  assign frame_unused = frame[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_q && !rx_s) begin
            baud_cnt <= '0;
            state    <= START;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == HALF_M1) begin
            if (!rx_s) begin
              bit_cnt  <= 4'd1;
              baud_cnt <= '0;
              state    <= DATA;
            end else begin
              state    <= IDLE;
              busy_q   <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 4'd1;
            // Leaving at mid-stop lets the next start edge be caught with no gap.
            if (bit_cnt == BIT_STP) state <= CHECK;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        CHECK: begin
          data_q  <= res.data;
          perr_q  <= res.perr;
          ferr_q  <= res.ferr;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at BAUD_DIV=16, even parity.
module tb_uart_rx_ctrl;

  localparam int B = 16;
  // 2 synchronizer flops + 1 edge-detect cycle ahead of the 169-cycle frame latency.
  localparam int LAT_FROM_DRIVE = 3 + B / 2 + 10 * B + 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  int         vcnt = 0;
  int         busy_cnt = 0;
  int         v_cyc = 0;
  int         v_cyc_prev = 0;
  logic [7:0] d_last = 8'h00;
  logic [7:0] d_prev = 8'h00;
  logic       pe_last = 1'b0;
  logic       fe_last = 1'b0;
  int         t0;
  int         b0;

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(.BAUD_DIV(B), .ODD_PARITY(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (u_if.o_busy) busy_cnt++;
    if (u_if.o_valid) begin
      vcnt++;
      v_cyc_prev = v_cyc;
      v_cyc      = cyc;
      d_prev     = d_last;
      d_last     = u_if.o_data;
      pe_last    = u_if.o_parity_err;
      fe_last    = u_if.o_frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      u_if.i_rx = f[i];
      tick(B);
    end
  endtask

  initial begin
    rst       = 1'b0;
    u_if.i_rx = 1'b1;
    tick(3);
    chk("rst_valid", 32'(u_if.o_valid), 32'd0);
    chk("rst_data",  32'(u_if.o_data), 32'h00);
    chk("rst_perr",  32'(u_if.o_parity_err), 32'd0);
    chk("rst_ferr",  32'(u_if.o_frame_err), 32'd0);
    chk("rst_busy",  32'(u_if.o_busy), 32'd0);
    rst = 1'b1;
    tick(5);

    // 0x55, correct even parity
    t0 = cyc;
    send_bits(mk(8'h55, 1'b0, 1'b1), 11);
    tick(4);
    chk("f55_count",   32'(vcnt), 32'd1);
    chk("f55_data",    32'(d_last), 32'h55);
    chk("f55_perr",    32'(pe_last), 32'd0);
    chk("f55_ferr",    32'(fe_last), 32'd0);
    chk("f55_latency", 32'(v_cyc - t0), 32'(LAT_FROM_DRIVE));

    // 0xA3 with parity bit flipped (correct even parity would be 0)
    send_bits(mk(8'hA3, 1'b1, 1'b1), 11);
    tick(4);
    chk("fa3_count", 32'(vcnt), 32'd2);
    chk("fa3_data",  32'(d_last), 32'hA3);
    chk("fa3_perr",  32'(pe_last), 32'd1);
    chk("fa3_ferr",  32'(fe_last), 32'd0);

    // 0x0F with stop=0, line stays low afterwards
    send_bits(mk(8'h0F, 1'b0, 1'b0), 11);
    tick(40);
    chk("f0f_count", 32'(vcnt), 32'd3);
    chk("f0f_data",  32'(d_last), 32'h0F);
    chk("f0f_perr",  32'(pe_last), 32'd0);
    chk("f0f_ferr",  32'(fe_last), 32'd1);
    chk("f0f_busy_low_line", 32'(u_if.o_busy), 32'd0);
    u_if.i_rx = 1'b1;
    tick(20);
    chk("f0f_no_retrigger", 32'(vcnt), 32'd3);

    // 4-cycle low glitch: busy from detect edge to mid-start sample
    b0 = busy_cnt;
    u_if.i_rx = 1'b0;
    tick(4);
    u_if.i_rx = 1'b1;
    tick(30);
    chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    chk("glitch_no_valid",    32'(vcnt), 32'd3);
    chk("glitch_data_held",   32'(u_if.o_data), 32'h0F);

    // reset in the middle of a frame, then a clean frame
    send_bits(mk(8'h99, 1'b0, 1'b1), 6);
    rst       = 1'b0;
    u_if.i_rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(20);
    chk("abort_no_valid", 32'(vcnt), 32'd3);
    chk("abort_busy",     32'(u_if.o_busy), 32'd0);
    chk("abort_data_clr", 32'(u_if.o_data), 32'h00);
    send_bits(mk(8'h3C, 1'b0, 1'b1), 11);
    tick(4);
    chk("f3c_count", 32'(vcnt), 32'd4);
    chk("f3c_data",  32'(d_last), 32'h3C);
    chk("f3c_perr",  32'(pe_last), 32'd0);
    chk("f3c_ferr",  32'(fe_last), 32'd0);

    // back-to-back 0x01 then 0xFF, no idle gap
    send_bits(mk(8'h01, 1'b1, 1'b1), 11);
    send_bits(mk(8'hFF, 1'b0, 1'b1), 11);
    tick(4);
    chk("b2b_count",   32'(vcnt), 32'd6);
    chk("b2b_first",   32'(d_prev), 32'h01);
    chk("b2b_second",  32'(d_last), 32'hFF);
    chk("b2b_spacing", 32'(v_cyc - v_cyc_prev), 32'd176);
    chk("b2b_perr",    32'(pe_last), 32'd0);
    chk("b2b_ferr",    32'(fe_last), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
